// File: rtl/plot_arbiter.sv
// Round-robin pixel-port arbiter with burst lock, clipping and a one-cycle
// registered output stage feeding the 160x120 VGA adapter.

module plot_arbiter_lane #(
  parameter int SW = 160,
  parameter int SH = 120
) (
  input  logic [7:0] x_i,
  input  logic [6:0] y_i,
  input  logic [2:0] c_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] c_o,
  output logic       inb_o
);
  assign x_o   = x_i;
  assign y_o   = y_i;
  assign c_o   = c_i;
  // unsigned compare at full width against the screen limits
  assign inb_o = ({24'd0, x_i} < 32'(SW)) && ({25'd0, y_i} < 32'(SH));
endmodule

module plot_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120,
  parameter int MAX_BURST     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [7*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic [2:0]           owner,
  output logic                 locked,
  output logic [15:0]          clip_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam bit CAN_LOCK = (MAX_BURST > 1);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic {ARB, LOCK} state_t;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic [NUM_REQ-1:0][7:0] lx;
  logic [NUM_REQ-1:0][6:0] ly;
  logic [NUM_REQ-1:0][2:0] lc;
  logic [NUM_REQ-1:0]      linb;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    plot_arbiter_lane #(.SW(SCREEN_WIDTH), .SH(SCREEN_HEIGHT)) u_lane (
      .x_i  (req_x[8*i +: 8]),
      .y_i  (req_y[7*i +: 7]),
      .c_i  (req_colour[3*i +: 3]),
      .x_o  (lx[i]),
      .y_o  (ly[i]),
      .c_o  (lc[i]),
      .inb_o(linb[i])
    );
  end

  state_t        state_q, state_d;
  idx_t          ptr_q, ptr_d;
  idx_t          own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pix_t          pix_q, pix_d;
  logic          plot_q;
  logic [15:0]   clip_q;

  logic hit, gv, inb;
  idx_t gidx, gsel, pi;
  int   p;

  function automatic idx_t wrap_inc(idx_t i);
    int n;
    n = int'(i) + 1;
    if (n >= NUM_REQ) n = 0;
    return idx_t'(n);
  endfunction

  // first requesting index at or above the pointer, wrapping
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    p    = 0;
    pi   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = int'(ptr_q) + k;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      pi = idx_t'(p);
      if (!hit && req[pi]) begin
        hit  = 1'b1;
        gidx = pi;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    gv      = 1'b0;
    gsel    = gidx;
    case (state_q)
      ARB: begin
        if (hit) begin
          gv    = 1'b1;
          ptr_d = wrap_inc(gidx);
          if (lock[gidx] && CAN_LOCK) begin
            state_d = LOCK;
            own_d   = gidx;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCK: begin
        gsel = own_q;
        if (req[own_q]) begin
          gv    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (!lock[own_q] || cnt_d == CW'(MAX_BURST)) begin
            state_d = ARB;
            ptr_d   = wrap_inc(own_q);
            cnt_d   = '0;
          end
        end else if (!lock[own_q]) begin
          // owner let go while idle: release without a pixel
          state_d = ARB;
          ptr_d   = wrap_inc(own_q);
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
    if (reset) gv = 1'b0;
    gnt = '0;
    if (gv) gnt[gsel] = 1'b1;
    pix_d = '{x: lx[gsel], y: ly[gsel], c: lc[gsel]};
    inb   = linb[gsel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      plot_q  <= 1'b0;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      if (gv) begin
        pix_q  <= pix_d;
        plot_q <= inb;
        if (!inb && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
      end else begin
        plot_q <= 1'b0;
      end
    end
  end

  assign x          = pix_q.x;
  assign y          = pix_q.y;
  assign colour     = pix_q.c;
  assign plot       = plot_q;
  assign owner      = 3'(own_q);
  assign locked     = (state_q == LOCK);
  assign clip_count = clip_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// Randomized and directed bench for plot_arbiter against a rule-level model.

module tb_plot_arbiter;
  localparam int N  = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   req, lock;
  logic [7:0]     rx [N];
  logic [6:0]     ry [N];
  logic [2:0]     rc [N];
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]   gnt;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot, locked;
  logic [2:0]     owner;
  logic [15:0]    clip_count;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_x[8*i +: 8]      = rx[i];
    assign req_y[7*i +: 7]      = ry[i];
    assign req_colour[3*i +: 3] = rc[i];
  end

  plot_arbiter #(.NUM_REQ(N), .SCREEN_WIDTH(160), .SCREEN_HEIGHT(120), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .gnt(gnt), .x(x), .y(y), .colour(colour), .plot(plot),
    .owner(owner), .locked(locked), .clip_count(clip_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // model: who may write, and what the adapter should see next
  int m_ptr, m_own, m_cnt, m_g;
  bit m_lk;
  int ex, ey, ec, ep, eclip;

  task automatic mreset();
    m_ptr = 0; m_own = 0; m_cnt = 0; m_lk = 0;
    ex = 0; ey = 0; ec = 0; ep = 0; eclip = 0;
  endtask

  function automatic int pick();
    if (m_lk) return req[m_own] ? m_own : -1;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic mupd(input int g);
    if (g >= 0) begin
      ex = rx[g]; ey = ry[g]; ec = rc[g];
      ep = (ex < 160 && ey < 120) ? 1 : 0;
      if (ep == 0 && eclip < 65535) eclip++;
    end else ep = 0;
    if (!m_lk) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (lock[g] && MB > 1) begin m_lk = 1; m_own = g; m_cnt = 1; end
      end
    end else if (g >= 0) begin
      m_cnt++;
      if (!lock[m_own] || m_cnt == MB) begin m_lk = 0; m_ptr = (m_own + 1) % N; end
    end else if (!lock[m_own]) begin
      m_lk = 0; m_ptr = (m_own + 1) % N;
    end
  endtask

  task automatic chk_out();
    chk("plot", int'(plot), ep);
    chk("x", int'(x), ex);
    chk("y", int'(y), ey);
    chk("colour", int'(colour), ec);
    chk("locked", int'(locked), int'(m_lk));
    if (m_lk) chk("owner", int'(owner), m_own);
    chk("clip", int'(clip_count), eclip);
  endtask

  // entered at posedge+1 with inputs already driven
  task automatic cyc();
    #2;
    m_g = pick();
    chk("gnt", int'(gnt), (m_g < 0) ? 0 : (1 << m_g));
    @(posedge clk); #1;
    mupd(m_g);
    chk_out();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mreset();
    chk_out();
  endtask

  task automatic setpix(input int i, input int px, input int py, input int pc);
    rx[i] = 8'(px); ry[i] = 7'(py); rc[i] = 3'(pc);
  endtask

  bit [N-1:0] pend;

  initial begin
    reset = 1'b1;
    req = '1; lock = '0;
    for (int i = 0; i < N; i++) setpix(i, 0, 0, 0);
    mreset();
    reset_dut();

    // alternating round-robin
    setpix(0, 10, 11, 1); setpix(1, 20, 21, 2);
    req = 2'b11; lock = 2'b00;
    repeat (4) cyc();

    // locked burst hits MAX_BURST, then requester 1 gets in
    lock = 2'b01;
    repeat (4) begin cyc(); chk("burst_gnt_hist", int'(plot), 1); end
    lock = 2'b00;
    cyc();

    // idle hold blocks requester 1, release without a pixel
    reset_dut();
    req = 2'b01; lock = 2'b01;
    cyc();
    req = 2'b10;
    repeat (3) cyc();
    chk("hold_locked", int'(locked), 1);
    lock = 2'b00;
    cyc();
    cyc();

    // clipping bounds
    reset_dut();
    req = 2'b01; lock = 2'b00;
    setpix(0, 160, 5, 3); cyc();
    setpix(0, 5, 120, 4); cyc();
    setpix(0, 159, 119, 5); cyc();
    chk("clip2", int'(clip_count), 2);
    req = 2'b00; cyc();

    // reset in the middle of a burst
    req = 2'b01; lock = 2'b01; setpix(0, 30, 40, 6);
    repeat (3) cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_gnt", int'(gnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mreset();
    req = 2'b11; lock = 2'b00;
    cyc();

    // randomized traffic
    reset_dut();
    pend = '0; lock = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          setpix(i, $urandom_range(0, 191), $urandom_range(0, 127), $urandom_range(0, 7));
        end
        if ($urandom_range(0, 3) == 0) lock[i] = ~lock[i];
      end
      req = pend;
      cyc();
      if (m_g >= 0) pend[m_g] = 1'b0;
    end

    // clip counter saturation
    reset_dut();
    req = 2'b01; lock = 2'b00; setpix(0, 200, 10, 1);
    while (eclip < 65534) begin
      m_g = pick();
      @(posedge clk); #1;
      mupd(m_g);
    end
    chk("clip_fffe", int'(clip_count), 65534);
    repeat (3) cyc();
    chk("clip_sat", int'(clip_count), 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
